// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_ctrl_pkg;

    localparam int WIDTH   = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: owns the fetch PC, issues one outstanding IMEM
// request at a time, and drops responses made stale by an EX redirect.
//
// state | meaning
// IDLE  | one cycle after reset, IMEM responses ignored
// REQ   | launch a request (when allowed) and hold it until granted
// WAIT  | request granted, waiting for the single response
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] next_pc,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetched_instr,
    output logic             fetched_valid
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_req_addr;
    logic             r_req_active;
    logic             r_kill;
    logic [WIDTH-1:0] r_next_pc;
    logic             r_fetch_valid;
    logic [WIDTH-1:0] r_fetched_instr;
    logic             r_fetched_valid;

    logic             w_req;
    logic             w_launch;
    logic             w_gnt_fire;
    logic             w_rsp;
    logic             w_deliver;
    logic             w_in_flight;
    logic [WIDTH-1:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~WIDTH'(3);

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_launch    = 1'b0;
        w_gnt_fire  = 1'b0;
        w_rsp       = 1'b0;
        w_deliver   = 1'b0;
        w_in_flight = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                w_req       = r_req_active;
                w_launch    = !r_req_active && !stall_i && !redirect_valid;
                w_gnt_fire  = r_req_active && imem_gnt;
                w_in_flight = r_req_active;
                if (w_gnt_fire) w_state_nxt = WAIT;
            end
            WAIT: begin
                w_in_flight = 1'b1;
                w_rsp       = imem_rvalid;
                w_deliver   = imem_rvalid && !r_kill && !redirect_valid;
                if (imem_rvalid) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // The request address is captured at launch so a redirect cannot move
    // imem_addr while the request is still waiting for its grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_addr   <= '0;
            r_req_active <= 1'b0;
            r_kill       <= 1'b0;
        end else begin
            if (w_launch) begin
                r_req_active <= 1'b1;
                r_req_addr   <= r_pc;
            end else if (w_gnt_fire) begin
                r_req_active <= 1'b0;
            end

            if (redirect_valid)  r_pc <= w_redirect_pc;
            else if (w_deliver)  r_pc <= r_req_addr + WIDTH'(PC_STEP);

            if (w_rsp)                              r_kill <= 1'b0;
            else if (redirect_valid && w_in_flight) r_kill <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_pc       <= '0;
            r_fetch_valid   <= 1'b0;
            r_fetched_instr <= '0;
            r_fetched_valid <= 1'b0;
        end else begin
            r_fetch_valid   <= w_gnt_fire && !r_kill && !redirect_valid;
            r_fetched_valid <= w_deliver;
            if (w_gnt_fire) r_next_pc       <= r_req_addr;
            if (w_deliver)  r_fetched_instr <= imem_rdata;
        end
    end

    assign imem_req      = w_req;
    assign imem_addr     = w_req ? r_req_addr : '0;
    assign next_pc       = r_next_pc;
    assign fetch_valid   = r_fetch_valid;
    assign fetched_instr = r_fetched_instr;
    assign fetched_valid = r_fetched_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl, plus a second instance with a
// wrapping reset PC served by an always-grant responder.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] next_pc;
    logic        fetch_valid;
    logic [31:0] fetched_instr;
    logic        fetched_valid;

    logic        req2, gnt2, fv2, fdv2;
    logic        rvalid2 = 1'b0;
    logic [31:0] addr2, npc2, instr2;
    logic [31:0] rdata2 = 32'h0000_0013;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_dlv = 0;
    int n2 = 0;
    logic [31:0] a2 [2];
    int t [4];

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .next_pc(next_pc), .fetch_valid(fetch_valid),
        .fetched_instr(fetched_instr), .fetched_valid(fetched_valid)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .next_pc(npc2), .fetch_valid(fv2),
        .fetched_instr(instr2), .fetched_valid(fdv2)
    );

    assign gnt2 = req2;
    always @(posedge clk) rvalid2 <= rst ? 1'b0 : (req2 && gnt2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (req2 && n2 < 2) begin
            a2[n2] = addr2;
            n2++;
        end
    endtask

    task automatic wait_req(input logic [31:0] exp_addr, input string tag);
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, exp_addr);
    endtask

    task automatic fetch(input logic [31:0] a, input int dly, input logic [31:0] d, input string tag);
        wait_req(a, tag);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk({tag, "_hold_req"}, 32'(imem_req), 32'd1);
            chk({tag, "_hold_addr"}, imem_addr, a);
            chk({tag, "_hold_fv"}, 32'(fetch_valid), 32'd0);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk({tag, "_fv"}, 32'(fetch_valid), 32'd1);
        chk({tag, "_next_pc"}, next_pc, a);
        chk({tag, "_req_low"}, 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        tick();
        imem_rvalid = 1'b0;
        chk({tag, "_fdv"}, 32'(fetched_valid), 32'd1);
        chk({tag, "_instr"}, fetched_instr, d);
        last_dlv = cyc;
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_fdv", 32'(fetched_valid), 32'd0);
        chk("rst_instr", fetched_instr, 32'd0);
        chk("wrap_rst_addr", addr2, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_req", 32'(imem_req), 32'd0);

        // back-to-back sequential fetch, best-case IMEM
        fetch(32'h0, 0, 32'h1111_0000, "seq0"); t[0] = last_dlv;
        fetch(32'h4, 0, 32'h1111_0004, "seq4"); t[1] = last_dlv;
        fetch(32'h8, 0, 32'h1111_0008, "seq8"); t[2] = last_dlv;
        fetch(32'hC, 0, 32'h1111_000C, "seqC"); t[3] = last_dlv;
        for (int i = 1; i < 4; i++) chk("rate", 32'(t[i] - t[i-1]), 32'd3);
        chk("wrap_n", 32'(n2), 32'd2);
        chk("wrap_first", a2[0], 32'hFFFF_FFFC);
        chk("wrap_second", a2[1], 32'h0000_0000);

        // grant delayed 3 cycles
        fetch(32'h10, 3, 32'h2222_0010, "dly");

        // stall during WAIT: response delivered, no new request
        wait_req(32'h14, "st");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        stall_i  = 1'b1;
        chk("st_fv", 32'(fetch_valid), 32'd1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_0014;
        tick();
        imem_rvalid = 1'b0;
        chk("st_fdv", 32'(fetched_valid), 32'd1);
        chk("st_instr", fetched_instr, 32'h3333_0014);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_no_req", 32'(imem_req), 32'd0);
        end
        stall_i = 1'b0;

        // redirect while waiting: response dropped, fetch resumes at 0x100
        wait_req(32'h18, "rdw");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0018;
        tick();
        imem_rvalid = 1'b0;
        chk("rdw_drop", 32'(fetched_valid), 32'd0);
        fetch(32'h100, 0, 32'h4444_0100, "rdw_tgt");

        // redirect coincident with rvalid
        wait_req(32'h104, "rdr");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hBAD0_0104;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        chk("rdr_drop", 32'(fetched_valid), 32'd0);
        fetch(32'h200, 0, 32'h5555_0200, "rdr_tgt");

        // redirect together with stall: PC moves, request waits for stall release
        stall_i        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h305;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_req", 32'(imem_req), 32'd0);
        end
        stall_i = 1'b0;
        fetch(32'h304, 0, 32'h6666_0304, "rs_tgt");

        // reset mid-WAIT with a late response
        wait_req(32'h308, "mr");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_fv", 32'(fetch_valid), 32'd0);
        chk("mr_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0308;
        tick();
        imem_rvalid = 1'b0;
        chk("mr_drop", 32'(fetched_valid), 32'd0);
        fetch(32'h0, 0, 32'h7777_0000, "mr_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
